// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule types, constants and word helpers.
// Combinational helpers only; no latency and no flow control.
// Used by the key expander and reusable by the cipher datapath.
package aes_pkg;

    localparam int NR     = 10;
    localparam int KEY_W  = 128;
    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [3:0]        round_t;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    // Constant byte sits in the top byte of the word.
    function automatic word_t rcon(input round_t i);
        case (i)
            4'd1:    return 32'h01000000;
            4'd2:    return 32'h02000000;
            4'd3:    return 32'h04000000;
            4'd4:    return 32'h08000000;
            4'd5:    return 32'h10000000;
            4'd6:    return 32'h20000000;
            4'd7:    return 32'h40000000;
            4'd8:    return 32'h80000000;
            4'd9:    return 32'h1b000000;
            4'd10:   return 32'h36000000;
            default: return 32'h00000000;
        endcase
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// AES forward S-box for one byte.
// Purely combinational; zero latency.
// No flow control; output follows input.
module aes_sbox (
    input  logic [7:0] data,
    output logic [7:0] subst
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

    // Multiplicative inverse as x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0.
    function automatic logic [7:0] ginv(input logic [7:0] x);
        logic [7:0] s;
        logic [7:0] r;
        s = x;
        r = 8'h01;
        for (int k = 1; k < 8; k++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv   = ginv(data);
        subst = inv
              ^ {inv[6:0], inv[7]}
              ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]}
              ^ 8'h63;
    end

endmodule

// File: rtl/aes128_key_expander.sv
// Sequential AES-128 key schedule: emits round keys 0..10 for one loaded key.
// Round 0 valid the cycle after start is accepted; one key per cycle when ready.
// Valid/ready: key and round index hold while valid & !ready; outputs are registered.
module aes128_key_expander
    import aes_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_W-1:0] key_in,
    input  logic             rk_ready,
    output logic             rk_valid,
    output logic [KEY_W-1:0] rk_out,
    output logic [3:0]       rk_round,
    output logic             busy,
    output logic             done
);

    state_t           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    round_t           r_q, r_d;
    logic             done_q, done_d;

    word_t rot, sub, t;
    word_t w0n, w1n, w2n, w3n;

    assign rot = rot_word(key_q[31:0]);

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .data  (rot[8*g +: 8]),
            .subst (sub[8*g +: 8])
        );
    end

    always_comb begin
        t   = sub ^ rcon(r_q + 4'd1);
        w0n = key_q[127:96] ^ t;
        w1n = key_q[95:64]  ^ w0n;
        w2n = key_q[63:32]  ^ w1n;
        w3n = key_q[31:0]   ^ w2n;
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        r_d     = r_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    key_d   = key_in;
                    r_d     = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (rk_ready) begin
                    if (r_q == round_t'(NR)) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        key_d = {w0n, w1n, w2n, w3n};
                        r_d   = r_q + 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            r_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            r_q     <= r_d;
            done_q  <= done_d;
        end
    end

    assign rk_valid = (state_q == EMIT);
    assign busy     = (state_q == EMIT);
    assign rk_out   = key_q;
    assign rk_round = r_q;
    assign done     = done_q;

endmodule

// File: tb/tb_aes128_key_expander.sv
// Randomized bench for aes128_key_expander against a word-array FIPS-197 key schedule model.
module tb_aes128_key_expander;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] key_in;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         busy;
    logic         done;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox_t [0:255];
    logic [127:0] ref_keys [0:10];

    always #5 clk = ~clk;

    aes128_key_expander dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in   (key_in),
        .rk_ready (rk_ready),
        .rk_valid (rk_valid),
        .rk_out   (rk_out),
        .rk_round (rk_round),
        .busy     (busy),
        .done     (done)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] a, input int n);
        logic [15:0] d;
        d = {a, a} << n;
        return d[15:8];
    endfunction

    // S-box table built by walking the field with generator 3 and its inverse.
    task automatic build_sbox();
        logic [7:0] p, q;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            sbox_t[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    task automatic compute_ref(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] temp;
        logic [7:0]  rc;
        rc   = 8'h01;
        w[0] = key[127:96];
        w[1] = key[95:64];
        w[2] = key[63:32];
        w[3] = key[31:0];
        for (int i = 4; i < 44; i++) begin
            temp = w[i-1];
            if (i % 4 == 0) begin
                temp = {temp[23:0], temp[31:24]};
                temp = {sbox_t[temp[31:24]], sbox_t[temp[23:16]], sbox_t[temp[15:8]], sbox_t[temp[7:0]]};
                temp = temp ^ {rc, 24'h0};
                rc   = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ temp;
        end
        for (int j = 0; j <= 10; j++)
            ref_keys[j] = {w[4*j], w[4*j+1], w[4*j+2], w[4*j+3]};
    endtask

    function automatic logic [127:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Called at a sample point (1 time unit after a rising edge) with the DUT idle,
    // unless skip_start says start was already accepted by the caller.
    task automatic run_key(input string name, input logic [127:0] key, input int ready_pct,
                           input int stall_round, input int start_round,
                           input bit skip_start, input bit chain, input logic [127:0] chain_key);
        int idx, cyc, busy_cnt, stalled;
        bit hs;
        compute_ref(key);
        if (!skip_start) begin
            start  = 1'b1;
            key_in = key;
            @(posedge clk); #1;
            start  = 1'b0;
        end
        idx = 0; cyc = 0; busy_cnt = 0; stalled = 0;
        while (idx <= 10 && cyc < 300) begin
            check({name, "_valid"}, 128'(rk_valid), 128'(1));
            check({name, "_round"}, 128'(rk_round), 128'(idx));
            check({name, "_key"},   rk_out, ref_keys[idx]);
            check({name, "_done_low"}, 128'(done), 128'(0));
            if (busy) busy_cnt++;
            if (idx == stall_round && stalled < 5) begin
                rk_ready = 1'b0;
                stalled++;
            end else begin
                rk_ready = ($urandom_range(99) < ready_pct);
            end
            start  = (idx == start_round) && rk_ready == 1'b0 ? 1'b1 : (idx == start_round);
            key_in = rand_key();
            hs     = rk_ready;
            @(posedge clk); #1;
            start  = 1'b0;
            cyc++;
            if (hs) idx++;
        end
        check({name, "_completed"}, 128'(idx), 128'(11));
        check({name, "_busy_cycles"}, 128'(busy_cnt), 128'(cyc));
        if (ready_pct == 100 && stall_round < 0)
            check({name, "_cycles"}, 128'(cyc), 128'(11));
        check({name, "_done"},       128'(done),     128'(1));
        check({name, "_valid_drop"}, 128'(rk_valid), 128'(0));
        check({name, "_busy_drop"},  128'(busy),     128'(0));
        rk_ready = 1'b0;
        if (chain) begin
            start  = 1'b1;
            key_in = chain_key;
        end
        @(posedge clk); #1;
        start = 1'b0;
        check({name, "_done_pulse"}, 128'(done), 128'(0));
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_valid"}, 128'(rk_valid), 128'(0));
        check({name, "_out"},   rk_out,         128'(0));
        check({name, "_round"}, 128'(rk_round), 128'(0));
        check({name, "_busy"},  128'(busy),     128'(0));
        check({name, "_done"},  128'(done),     128'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k;
        rst_n    = 1'b0;
        start    = 1'b0;
        key_in   = '0;
        rk_ready = 1'b0;
        build_sbox();
        #12;
        check_all_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("idle");

        compute_ref(128'h2b7e151628aed2a6abf7158809cf4f3c);
        check("model_fips_r1",  ref_keys[1],  128'ha0fafe1788542cb123a339392a6c7605);
        check("model_fips_r10", ref_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        run_key("fips", 128'h2b7e151628aed2a6abf7158809cf4f3c, 100, -1, -1, 1'b0, 1'b0, '0);

        compute_ref(128'h0);
        check("model_zero_r1",  ref_keys[1],  128'h62636363626363636263636362636363);
        check("model_zero_r10", ref_keys[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);
        run_key("zero", 128'h0, 100, -1, -1, 1'b0, 1'b0, '0);

        run_key("stall", rand_key(), 100, 3, -1, 1'b0, 1'b0, '0);
        run_key("ignore_start", rand_key(), 100, -1, 5, 1'b0, 1'b0, '0);

        // Abort with reset at round 6, then a clean run.
        k = rand_key();
        start    = 1'b1;
        key_in   = k;
        rk_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 30 && !(rk_valid && rk_round == 4'd6); i++) begin
            @(posedge clk); #1;
        end
        check("abort_reach6", 128'(rk_round), 128'(6));
        rst_n = 1'b0;
        #2;
        check_all_zero("abort_async");
        @(posedge clk); #1;
        check_all_zero("abort_held");
        rst_n    = 1'b1;
        rk_ready = 1'b0;
        @(posedge clk); #1;
        check_all_zero("abort_after");
        run_key("post_abort", rand_key(), 100, -1, -1, 1'b0, 1'b0, '0);

        // Start asserted in the done cycle is taken immediately.
        k = rand_key();
        run_key("chain_a", rand_key(), 100, -1, -1, 1'b0, 1'b1, k);
        run_key("chain_b", k, 100, -1, -1, 1'b1, 1'b0, '0);

        for (int n = 0; n < 6; n++)
            run_key("random", rand_key(), 60, -1, -1, 1'b0, 1'b0, '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes128_key_expander.md
Name: aes128_key_expander

Overview:
Sequential AES-128 key schedule that sits directly downstream of the round-constant lookup and feeds round keys to the cipher datapath. It loads a 128-bit cipher key and emits round keys 0..10 in order, one per accepted handshake. Each next key is computed in place from the current key using SubWord/RotWord and the round constant. The block never stores all eleven keys.

Parameters:
NR, 10, number of rounds; only 10 is supported (AES-128), fixed by the package.
KEY_W, 128, key and round-key width in bits; fixed.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  load request; sampled only in IDLE.
key_in  in  128  cipher key; captured when start is accepted. Word w0 = key_in[127:96].
rk_ready  in  1  consumer accepts rk_out this cycle.
rk_valid  out  1  rk_out/rk_round hold a valid round key.
rk_out  out  128  current round key, with w0 in [127:96].
rk_round  out  4  index of rk_out, 0..10.
busy  out  1  high from the cycle after start is accepted until done.
done  out  1  one-cycle pulse after round key 10 is accepted.

Behaviour:
- Reset (async assert, sync deassert handled externally): state=IDLE; key_reg=0; r=0. Outputs: rk_valid=0, rk_out=0, rk_round=0, busy=0, done=0. Reset asserted mid-sequence aborts it immediately; no done pulse.
- States:
  - IDLE: start=1 -> key_reg<=key_in, r<=0, go to EMIT. start while not in IDLE is ignored.
  - EMIT: rk_valid=1, rk_out=key_reg, rk_round=r, busy=1.
    - Handshake is rk_valid & rk_ready.
    - Handshake with r<10: key_reg<=next_key(key_reg, rcon(r+1)), r<=r+1, stay in EMIT.
    - Handshake with r==10: go to IDLE; done=1 for exactly that next cycle; rk_valid and busy drop in the same cycle.
    - No handshake: rk_out and rk_round stay stable (no change while valid & !ready).
- next_key: t = SubWord(RotWord(w3)) ^ rcon.
  - RotWord {a,b,c,d} -> {b,c,d,a}; SubWord applies the AES S-box per byte.
  - rcon(i) is the 32-bit value with the constant byte in [31:24]: 01,02,04,08,10,20,40,80,1b,36 for i=1..10.
  - w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
  - All arithmetic is bitwise XOR; no carries.
- Latency and throughput:
  - start accepted at edge k -> rk_valid=1 with round 0 after edge k.
  - With rk_ready held high: one key per cycle; round 10 appears 10 cycles after round 0; done 11 cycles after round 0.
- Simultaneous events:
  - start in the same cycle as the final handshake is ignored (state is not yet IDLE).
  - start in the done cycle is accepted (state is IDLE).
- Combinational paths: rk_ready -> outputs is not allowed. All outputs are registered or decoded from state/registers only.

Decomposition:
- Package aes_pkg holds:
  - constants NR=10, KEY_W=128, WORD_W=32;
  - typedef word_t [31:0] and round_t [3:0];
  - state enum {IDLE, EMIT};
  - functions rot_word() and the round-constant table, matching the existing round-constant lookup; the existing round_cf block may be instantiated instead, driven by r+1.
- Natural sub-module: aes_sbox, a combinational 8-bit S-box instantiated 4x for SubWord. It is also reusable by the cipher SubBytes stage.

Test Plan:
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse, rk_ready=1 -> round 0 = key; round 1 a0fafe1788542cb123a339392a6c7605; round 10 d014f9a8c9ee2589e13f0cc8b6630ca6; done one cycle after round 10; busy high for exactly 11 cycles.
- Key all-zero -> round 1 62636363626363636263636362636363; round 10 b4ef5bcb3e92e21123e951cf6f8f188e.
- Backpressure: rk_ready=0 for 5 cycles at rk_round=3 -> rk_out/rk_round stable throughout; sequence resumes correctly at round 4 when ready returns.
- start pulsed at rk_round=5 with a different key_in -> ignored; the remaining keys match the original key's schedule.
- rst_n pulsed low at rk_round=6 -> all outputs 0 immediately (asynchronously); no done pulse; a new start afterwards runs a full clean sequence.
- start asserted in the done cycle -> accepted; round 0 of the new key is valid on the next cycle.
